// File: rtl/asrv32_boot_loader.sv
// asrv32_boot_loader: parses one framed byte-stream image, writes it into main memory and releases asrv32_core.
// Optional ACK/NAK response channel is compiled in with `define ASRV32_BOOT_ACK_EN.
module asrv32_boot_loader #(
    parameter int unsigned MEMORY_DEPTH     = 1024,
    parameter int unsigned BOOT_WAIT_CYCLES = 1000000,
    parameter int unsigned BYTE_TIMEOUT     = 10000,
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [31:0] o_data_addr,
    output logic [31:0] o_data_out,
    output logic [3:0]  o_wr_mask,
    output logic        o_wr_en,
    output logic        o_busy,
    output logic        o_core_rst_n,
    output logic        o_error
`ifdef ASRV32_BOOT_ACK_EN
    ,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
`endif
);
    localparam logic [31:0] BOOT_TC = 32'(BOOT_WAIT_CYCLES - 1);
    localparam logic [31:0] BYTE_TC = 32'(BYTE_TIMEOUT - 1);
    localparam logic [32:0] DEPTH   = 33'(MEMORY_DEPTH);

    // SYNC hunt marker | LEN/ADDR header | DATA payload | CSUM check | DRAIN discard | RUN core released
    typedef enum logic [2:0] {
        S_SYNC, S_LEN, S_ADDR, S_DATA, S_CSUM, S_DRAIN, S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic        busy_q, core_rst_n_q;

    logic [31:0] full_addr;
    logic [32:0] end_addr;
    logic [31:0] wr_addr;
    logic [7:0]  csum_chk;

    always_comb begin
        full_addr = {i_rx_data, base_q[31:8]};
        end_addr  = {1'b0, full_addr} + {1'b0, len_q};
        wr_addr   = base_q + idx_q;
        csum_chk  = sum_q + i_rx_data;

        state_d   = state_q;
        timer_d   = timer_q + 32'd1;
        hdr_cnt_d = hdr_cnt_q;
        len_d     = len_q;
        base_d    = base_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;

        case (state_q)
            S_SYNC: begin
                if (i_rx_valid) begin
                    timer_d = '0;
                    if (i_rx_data == SYNC_BYTE) begin
                        state_d   = S_LEN;
                        err_d     = 1'b0;
                        hdr_cnt_d = '0;
                        idx_d     = '0;
                        sum_d     = '0;
                    end
                end else if (timer_q == BOOT_TC) begin
                    state_d = S_RUN;
                end
            end
            S_LEN: begin
                if (i_rx_valid) begin
                    timer_d   = '0;
                    len_d     = {i_rx_data, len_q[31:8]};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) state_d = S_ADDR;
                end else if (timer_q == BYTE_TC) begin
                    state_d = S_SYNC;
                    err_d   = 1'b1;
                end
            end
            S_ADDR: begin
                if (i_rx_valid) begin
                    timer_d   = '0;
                    base_d    = full_addr;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (end_addr > DEPTH) begin
                            state_d = S_DRAIN;
                            err_d   = 1'b1;
                        end else if (len_q == '0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end else if (timer_q == BYTE_TC) begin
                    state_d = S_SYNC;
                    err_d   = 1'b1;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    timer_d = '0;
                    wr_en_d = 1'b1;
                    addr_d  = wr_addr;
                    mask_d  = 4'b0001 << wr_addr[1:0];
                    data_d  = {4{i_rx_data}};
                    sum_d   = csum_chk;
                    idx_d   = idx_q + 32'd1;
                    if (idx_q == len_q - 32'd1) state_d = S_CSUM;
                end else if (timer_q == BYTE_TC) begin
                    state_d = S_SYNC;
                    err_d   = 1'b1;
                end
            end
            S_CSUM: begin
                if (i_rx_valid) begin
                    timer_d = '0;
                    if (csum_chk == 8'd0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_SYNC;
                        err_d   = 1'b1;
                    end
                end else if (timer_q == BYTE_TC) begin
                    state_d = S_SYNC;
                    err_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_rx_valid) begin
                    timer_d = '0;
                end else if (timer_q == BYTE_TC) begin
                    state_d = S_SYNC;
                end
            end
            S_RUN: begin
                timer_d = timer_q;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_SYNC;
            timer_q      <= '0;
            hdr_cnt_q    <= '0;
            len_q        <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            busy_q       <= 1'b1;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            hdr_cnt_q    <= hdr_cnt_d;
            len_q        <= len_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            busy_q       <= (state_q != S_RUN);
            core_rst_n_q <= (state_q == S_RUN);
        end
    end

    assign o_data_addr  = addr_q;
    assign o_data_out   = data_q;
    assign o_wr_mask    = mask_q;
    assign o_wr_en      = wr_en_q;
    assign o_busy       = busy_q;
    assign o_core_rst_n = core_rst_n_q;
    assign o_error      = err_q;

`ifdef ASRV32_BOOT_ACK_EN
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    // Error is always clear while a frame is in flight, so a rising error flags exactly one NAK.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else if (state_q == S_CSUM && state_d == S_RUN) begin
            tx_data_q  <= 8'h06;
            tx_valid_q <= 1'b1;
        end else if (err_d && !err_q) begin
            tx_data_q  <= 8'h15;
            tx_valid_q <= 1'b1;
        end else if (tx_valid_q && i_tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
`endif
endmodule

// File: tb/tb_asrv32_boot_loader.sv
// Scoreboard bench for asrv32_boot_loader: stimulus pushes expected memory writes, a monitor pops and compares them.
module tb_asrv32_boot_loader;
    localparam int unsigned MEMORY_DEPTH = 1024;
    localparam int unsigned BOOT_WAIT    = 300;
    localparam int unsigned BYTE_TO      = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] o_data_addr;
    logic [31:0] o_data_out;
    logic [3:0]  o_wr_mask;
    logic        o_wr_en;
    logic        o_busy;
    logic        o_core_rst_n;
    logic        o_error;
`ifdef ASRV32_BOOT_ACK_EN
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        tx_ready;
`endif

    always #5 clk = ~clk;

    asrv32_boot_loader #(
        .MEMORY_DEPTH    (MEMORY_DEPTH),
        .BOOT_WAIT_CYCLES(BOOT_WAIT),
        .BYTE_TIMEOUT    (BYTE_TO),
        .SYNC_BYTE       (8'hA5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_data_addr (o_data_addr),
        .o_data_out  (o_data_out),
        .o_wr_mask   (o_wr_mask),
        .o_wr_en     (o_wr_en),
        .o_busy      (o_busy),
        .o_core_rst_n(o_core_rst_n),
        .o_error     (o_error)
`ifdef ASRV32_BOOT_ACK_EN
        ,
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (tx_ready)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    int   vectors     = 0;
    int   miscompares = 0;
    wr_t  exp_q[$];
    logic [7:0] pl_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (o_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", o_data_addr, o_data_out);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", o_data_addr, w.addr);
                    check("wr_data", o_data_out, w.data);
                    check("wr_mask", {28'd0, o_wr_mask}, {28'd0, w.mask});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_g(input logic [7:0] b, input int gap_max);
        idle(int'($urandom_range(32'(gap_max), 0)));
        send_byte(b);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] good_csum();
        logic [7:0] s = 8'd0;
        foreach (pl_q[i]) s = s + pl_q[i];
        return 8'd0 - s;
    endfunction

    function automatic void fill_random(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
    endfunction

    // Reference model: an in-range frame writes payload byte i to addr+i, lane = address mod 4.
    task automatic send_frame(input logic [31:0] addr, input logic [7:0] csum, input int gap_max,
                              input bit expect_writes, output bit in_range);
        logic [31:0] len;
        logic [32:0] end_a;
        wr_t         w;
        len      = 32'(pl_q.size());
        end_a    = {1'b0, addr} + {1'b0, len};
        in_range = (end_a <= 33'(MEMORY_DEPTH));
        if (in_range && expect_writes) begin
            for (int i = 0; i < pl_q.size(); i++) begin
                w.addr = addr + 32'(i);
                w.data = {4{pl_q[i]}};
                w.mask = 4'b0001 << w.addr[1:0];
                exp_q.push_back(w);
            end
        end
        send_g(8'hA5, gap_max);
        for (int k = 0; k < 4; k++) send_g(len[8*k +: 8], gap_max);
        for (int k = 0; k < 4; k++) send_g(addr[8*k +: 8], gap_max);
        for (int i = 0; i < pl_q.size(); i++) send_g(pl_q[i], gap_max);
        send_g(csum, gap_max);
    endtask

    initial begin
        bit          rng;
        bit          good;
        int          len;
        logic [31:0] addr;
        logic [7:0]  cs;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
`ifdef ASRV32_BOOT_ACK_EN
        tx_ready = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("rst_wr_mask", {28'd0, o_wr_mask}, 32'd0);
        check("rst_addr", o_data_addr, 32'd0);
        check("rst_data", o_data_out, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd1);
        check("rst_core_rst_n", {31'd0, o_core_rst_n}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);

        // Known-good frame, then core release one cycle after the checksum.
        do_reset();
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'h10, 8'h56, 1, 1'b1, rng);
        check("a_core_at_csum", {31'd0, o_core_rst_n}, 32'd0);
        idle(1);
        check("a_core_after", {31'd0, o_core_rst_n}, 32'd1);
        check("a_busy", {31'd0, o_busy}, 32'd0);
        check("a_error", {31'd0, o_error}, 32'd0);
        idle(2);
        check("a_writes_done", 32'(exp_q.size()), 32'd0);
        pl_q = '{8'h01, 8'h02};
        send_frame(32'h20, good_csum(), 0, 1'b0, rng);
        idle(3);
        check("a_run_ignores_err", {31'd0, o_error}, 32'd0);

        // Bad checksum: writes happen, error set, core held; next good frame boots.
        do_reset();
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'h10, 8'h57, 0, 1'b1, rng);
        check("b_error", {31'd0, o_error}, 32'd1);
`ifdef ASRV32_BOOT_ACK_EN
        check("b_nak_valid", {31'd0, o_tx_valid}, 32'd1);
        check("b_nak_data", {24'd0, o_tx_data}, 32'h15);
`endif
        idle(3);
        check("b_core_held", {31'd0, o_core_rst_n}, 32'd0);
        check("b_busy", {31'd0, o_busy}, 32'd1);
        check("b_writes_done", 32'(exp_q.size()), 32'd0);
        fill_random(5);
        send_frame(32'h100, good_csum(), 2, 1'b1, rng);
        idle(2);
        check("b2_error_cleared", {31'd0, o_error}, 32'd0);
        check("b2_core", {31'd0, o_core_rst_n}, 32'd1);
        check("b2_writes_done", 32'(exp_q.size()), 32'd0);

        // Range violation: no writes, drain, then a fresh frame after the byte timeout.
        do_reset();
        fill_random(8);
        send_frame(32'h3FC, good_csum(), 1, 1'b1, rng);
        check("c_error", {31'd0, o_error}, 32'd1);
        check("c_core_held", {31'd0, o_core_rst_n}, 32'd0);
        idle(int'(BYTE_TO) + 2);
        fill_random(4);
        send_frame(32'h40, good_csum(), 1, 1'b1, rng);
        idle(2);
        check("c2_error", {31'd0, o_error}, 32'd0);
        check("c2_core", {31'd0, o_core_rst_n}, 32'd1);
        check("c2_writes_done", 32'(exp_q.size()), 32'd0);

        // Truncated header: timeout fires exactly BYTE_TIMEOUT cycles after the last byte.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        idle(int'(BYTE_TO) - 1);
        check("d_error_before_to", {31'd0, o_error}, 32'd0);
        idle(1);
        check("d_error_at_to", {31'd0, o_error}, 32'd1);
`ifdef ASRV32_BOOT_ACK_EN
        check("d_nak_data", {24'd0, o_tx_data}, 32'h15);
`endif
        idle(5);
        check("d_core_held", {31'd0, o_core_rst_n}, 32'd0);

        // Autoboot with silent line, then the frame is ignored.
        do_reset();
        idle(int'(BOOT_WAIT));
        check("e_core_before", {31'd0, o_core_rst_n}, 32'd0);
        idle(1);
        check("e_core_after", {31'd0, o_core_rst_n}, 32'd1);
        check("e_busy", {31'd0, o_busy}, 32'd0);
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'h10, 8'h56, 0, 1'b0, rng);
        idle(3);
        check("e_error", {31'd0, o_error}, 32'd0);
        check("e_still_run", {31'd0, o_core_rst_n}, 32'd1);

        // Empty payload, back-to-back bytes.
        do_reset();
        pl_q.delete();
        send_frame(32'($urandom_range(MEMORY_DEPTH, 0)), 8'h00, 0, 1'b1, rng);
        check("f_core_at_csum", {31'd0, o_core_rst_n}, 32'd0);
`ifdef ASRV32_BOOT_ACK_EN
        check("f_ack_valid", {31'd0, o_tx_valid}, 32'd1);
        check("f_ack_data", {24'd0, o_tx_data}, 32'h06);
`endif
        idle(1);
        check("f_core_after", {31'd0, o_core_rst_n}, 32'd1);
        check("f_error", {31'd0, o_error}, 32'd0);
`ifdef ASRV32_BOOT_ACK_EN
        idle(3);
        check("f_ack_held", {31'd0, o_tx_valid}, 32'd1);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        check("f_ack_dropped", {31'd0, o_tx_valid}, 32'd0);
`endif

        // Randomised frames against the reference rules.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            len = int'($urandom_range(12, 1));
            if ($urandom_range(3, 0) == 0)
                addr = 32'(MEMORY_DEPTH) - 32'(len) + 32'($urandom_range(8, 1));
            else
                addr = 32'($urandom_range(MEMORY_DEPTH - 32'(len), 0));
            good = ($urandom_range(2, 0) != 0);
            fill_random(len);
            cs = good ? good_csum() : good_csum() + 8'd1;
            send_frame(addr, cs, 2, 1'b1, rng);
            idle(2);
            check("r_error", {31'd0, o_error}, {31'd0, !(rng && good)});
            check("r_core", {31'd0, o_core_rst_n}, {31'd0, (rng && good)});
            check("r_writes_done", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
